// File: rtl/expr_result_checker.sv
// Capture/compare stage for expression-block results: compares DUT and golden beats,
// folds DUT results into a MISR signature, and reports pass/fail with first-failure details.
module expr_result_checker #(
  parameter int              WIDTH = 90,
  parameter int              SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int              CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  y_dut,
  input  logic [WIDTH-1:0]  y_ref,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_mismatch_idx,
  output logic [WIDTH-1:0]  first_mismatch_xor,
  output logic [SIG_W-1:0]  signature
);

  localparam int NSLICE = (WIDTH + SIG_W - 1) / SIG_W;
  localparam int PAD_W  = NSLICE * SIG_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   target_reg, target_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [CNT_W-1:0]   mm_count_reg, mm_count_next;
  logic [CNT_W-1:0]   mm_idx_reg, mm_idx_next;
  logic [WIDTH-1:0]   mm_xor_reg, mm_xor_next;
  logic [SIG_W-1:0]   sig_reg, sig_next;

  logic [PAD_W-1:0]   y_pad;
  logic [SIG_W-1:0]   slice [NSLICE];
  logic [SIG_W-1:0]   fold;
  logic [CNT_W-1:0]   count_inc;
  logic               accept;
  logic               mismatch;

  // The top slice is zero-extended so a partial slice folds cleanly.
  assign y_pad = PAD_W'(y_dut);

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign slice[gi] = y_pad[gi*SIG_W +: SIG_W];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int i = 0; i < NSLICE; i++) begin
      fold = fold ^ slice[i];
    end
  end

  assign accept    = in_valid && (state_reg == RUN);
  assign mismatch  = (y_dut != y_ref);
  assign count_inc = count_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    count_next    = count_reg;
    mm_count_next = mm_count_reg;
    mm_idx_next   = mm_idx_reg;
    mm_xor_next   = mm_xor_reg;
    sig_next      = sig_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          target_next   = num_vectors;
          count_next    = '0;
          mm_count_next = '0;
          mm_idx_next   = '0;
          mm_xor_next   = '0;
          sig_next      = SEED;
          state_next    = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          sig_next   = {sig_reg[SIG_W-2:0], 1'b0} ^ (sig_reg[SIG_W-1] ? POLY : '0) ^ fold;
          count_next = count_inc;
          if (mismatch) begin
            if (mm_count_reg != '1) begin
              mm_count_next = mm_count_reg + 1'b1;
            end
            // Only the first failing beat is recorded for diagnosis.
            if (mm_count_reg == '0) begin
              mm_idx_next = count_reg;
              mm_xor_next = y_dut ^ y_ref;
            end
          end
          if (count_inc == target_reg) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      target_reg   <= '0;
      count_reg    <= '0;
      mm_count_reg <= '0;
      mm_idx_reg   <= '0;
      mm_xor_reg   <= '0;
      sig_reg      <= SEED;
    end else begin
      state_reg    <= state_next;
      target_reg   <= target_next;
      count_reg    <= count_next;
      mm_count_reg <= mm_count_next;
      mm_idx_reg   <= mm_idx_next;
      mm_xor_reg   <= mm_xor_next;
      sig_reg      <= sig_next;
    end
  end

  assign in_ready           = (state_reg == RUN);
  assign busy               = (state_reg == RUN);
  assign done               = (state_reg == DONE);
  assign pass               = done && (mm_count_reg == '0);
  assign mismatch_count     = mm_count_reg;
  assign first_mismatch_idx = mm_idx_reg;
  assign first_mismatch_xor = mm_xor_reg;
  assign signature          = sig_reg;

endmodule

// File: tb/tb_expr_result_checker.sv
// Directed bench for expr_result_checker: hand-built vectors, expected values from
// constants and a small MISR reference.
module tb_expr_result_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_vectors;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] y_dut;
  logic [89:0] y_ref;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] mismatch_count;
  logic [15:0] first_mismatch_idx;
  logic [89:0] first_mismatch_xor;
  logic [31:0] signature;

  int checks = 0;
  int errors = 0;

  logic [89:0] vec [5];
  logic [89:0] one89;
  logic [31:0] exp_sig;
  logic        rdy_seen;

  expr_result_checker dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .num_vectors        (num_vectors),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .y_dut              (y_dut),
    .y_ref              (y_ref),
    .busy               (busy),
    .done               (done),
    .pass               (pass),
    .mismatch_count     (mismatch_count),
    .first_mismatch_idx (first_mismatch_idx),
    .first_mismatch_xor (first_mismatch_xor),
    .signature          (signature)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC-style MISR step with the three slices written out by hand.
  function automatic logic [31:0] misr(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic pulse_start(input logic [15:0] n);
    start       = 1'b1;
    num_vectors = n;
    @(posedge clk); #1;
    start       = 1'b0;
    $display("start n=%0d", n);
  endtask

  task automatic send(input logic vld, input logic [89:0] d, input logic [89:0] r);
    in_valid = vld;
    y_dut    = d;
    y_ref    = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("beat vld=%0b dut=%h ref=%h", vld, d, r);
  endtask

  initial begin
    vec[0] = 90'h2AB_CDEF0123_456789AB;
    vec[1] = 90'h155_00000000_FFFFFFFF;
    vec[2] = 90'h3FF_12345678_9ABCDEF0;
    vec[3] = 90'h001_DEADBEEF_CAFEF00D;
    vec[4] = 90'h200_80000001_00000000;
    one89  = 90'h1 << 89;
    reset = 1'b1; start = 1'b0; num_vectors = '0; in_valid = 1'b0;
    y_dut = '0; y_ref = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sig", signature, 32'hFFFFFFFF);
    check("rst_busy", {in_ready, busy, done, pass}, 4'b0000);
    check("rst_mm", {mismatch_count, first_mismatch_idx}, 32'h0);
    check("rst_xor", first_mismatch_xor, 90'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single zero beat
    pulse_start(16'd1);
    check("t1_rdy", {in_ready, busy, done}, 3'b110);
    send(1'b1, 90'h0, 90'h0);
    check("t1_done", {done, pass, busy, in_ready}, 4'b1100);
    check("t1_mm", mismatch_count, 16'd0);
    check("t1_sig", signature, 32'hFB3EE249);

    // four beats, beat 2 has bit 89 flipped
    pulse_start(16'd4);
    exp_sig = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      logic [89:0] d;
      d = (i == 2) ? (vec[i] ^ one89) : vec[i];
      if (i == 3) check("t2_notdone", done, 1'b0);
      send(1'b1, d, vec[i]);
      exp_sig = misr(exp_sig, d);
    end
    check("t2_done", {done, pass}, 2'b10);
    check("t2_mm", mismatch_count, 16'd1);
    check("t2_idx", first_mismatch_idx, 16'd2);
    check("t2_xor", first_mismatch_xor, one89);
    check("t2_sig", signature, exp_sig);

    // in_valid toggling 1,0,1,0,1; idle beats carry junk that must be ignored
    pulse_start(16'd3);
    exp_sig = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      if (i[0] == 1'b0) begin
        send(1'b1, vec[i/2], vec[i/2]);
        exp_sig = misr(exp_sig, vec[i/2]);
      end else begin
        send(1'b0, vec[4], 90'h0);
      end
      if (i == 3) check("t3_notdone", done, 1'b0);
    end
    check("t3_done", {done, pass}, 2'b11);
    check("t3_sig", signature, exp_sig);
    // in_valid in DONE must be ignored
    send(1'b1, vec[4], 90'h0);
    check("t3_hold", {signature, mismatch_count}, {exp_sig, 16'd0});

    // zero-length run
    rdy_seen = 1'b0;
    start = 1'b1; num_vectors = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    $display("start n=0");
    for (int i = 0; i < 3; i++) begin
      rdy_seen = rdy_seen | in_ready;
      if (i == 0) begin
        check("t4_done", {done, pass, busy}, 3'b110);
        check("t4_sig", signature, 32'hFFFFFFFF);
      end
      @(posedge clk); #1;
    end
    check("t4_rdy", rdy_seen, 1'b0);

    // reset mid-run after 2 of 5 beats (one mismatching)
    pulse_start(16'd5);
    send(1'b1, vec[0], vec[1]);
    send(1'b1, vec[1], vec[1]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset mid-run");
    check("t5_rst", {in_ready, busy, done, pass}, 4'b0000);
    check("t5_rst_mm", {mismatch_count, first_mismatch_idx}, 32'h0);
    check("t5_rst_sig", signature, 32'hFFFFFFFF);
    pulse_start(16'd5);
    exp_sig = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, vec[i], vec[i]);
      exp_sig = misr(exp_sig, vec[i]);
    end
    check("t5_done", {done, pass}, 2'b11);
    check("t5_mm", {mismatch_count, first_mismatch_idx}, 32'h0);
    check("t5_xor", first_mismatch_xor, 90'h0);
    check("t5_sig", signature, exp_sig);

    // start during RUN is ignored
    pulse_start(16'd3);
    exp_sig = 32'hFFFFFFFF;
    send(1'b1, vec[2], vec[2]);
    exp_sig = misr(exp_sig, vec[2]);
    pulse_start(16'd1);
    check("t6_ignored", {busy, done}, 2'b10);
    send(1'b1, vec[3], vec[3]);
    exp_sig = misr(exp_sig, vec[3]);
    check("t6_notdone", done, 1'b0);
    send(1'b1, vec[4], vec[4]);
    exp_sig = misr(exp_sig, vec[4]);
    check("t6_done", {done, pass}, 2'b11);
    check("t6_sig", signature, exp_sig);

    // start in DONE begins a new run; first beat mismatches
    pulse_start(16'd2);
    check("t7_restart", {done, busy, in_ready}, 3'b011);
    check("t7_clr", {signature, mismatch_count}, {32'hFFFFFFFF, 16'd0});
    send(1'b1, vec[1], vec[0]);
    send(1'b1, vec[2], vec[3]);
    check("t7_done", {done, pass}, 2'b10);
    check("t7_mm", mismatch_count, 16'd2);
    check("t7_idx", first_mismatch_idx, 16'd0);
    check("t7_xor", first_mismatch_xor, vec[1] ^ vec[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
